// File: rtl/d_cache_ctrl.sv
// d_cache_ctrl: direct-mapped, write-back, one-word-line data cache in front
// of a 256x32 backing memory with a fixed transfer latency.
// Optional feature macro DCACHE_STATS_EN enables the hit/miss counters;
// without it hit_cnt and miss_cnt are tied to zero.
module d_cache_ctrl #(
    parameter int LINES       = 16,
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        stall,
    input  logic [7:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 8 - IDX_W;
    localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, REFILL = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [TAG_W-1:0]   vtag_q, vtag_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q [LINES];
    logic [31:0]        data_q [LINES];
    logic [31:0]        mem_q [256];

    logic [IDX_W-1:0]   idx_s, dbg_idx_s;
    logic [TAG_W-1:0]   tag_s, dbg_tag_s;
    logic               req_s, hit_s;
    logic               line_we_s, fill_s, mem_we_s;
    logic [31:0]        line_wdata_s;

    assign idx_s     = addr[IDX_W-1:0];
    assign tag_s     = addr[7:IDX_W];
    assign dbg_idx_s = dbg_addr[IDX_W-1:0];
    assign dbg_tag_s = dbg_addr[7:IDX_W];
    assign req_s     = we | re;
    assign hit_s     = valid_q[idx_s] && (tag_q[idx_s] == tag_s);

    // Pipeline-facing outputs: stall on an IDLE miss or any memory transfer, load data only on an IDLE load hit.
    always_comb begin
        stall = 1'b0;
        rdata = 32'd0;
        if (rst) begin
            stall = 1'b0;
            rdata = 32'd0;
        end else if (state_q != IDLE) begin
            stall = 1'b1;
        end else if (req_s && !hit_s) begin
            stall = 1'b1;
        end else if (re && !we && hit_s) begin
            rdata = data_q[idx_s];
        end else begin
            rdata = 32'd0;
        end
    end

    // Debug port: a dirty matching line is newer than the backing memory, everything else comes from memory.
    always_comb begin
        if (valid_q[dbg_idx_s] && dirty_q[dbg_idx_s] && (tag_q[dbg_idx_s] == dbg_tag_s)) begin
            dbg_data = data_q[dbg_idx_s];
        end else begin
            dbg_data = mem_q[dbg_addr];
        end
    end

    // Next-state logic: miss detection, write-back/refill latency counting and line/memory write strobes.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        vtag_d       = vtag_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        line_we_s    = 1'b0;
        fill_s       = 1'b0;
        mem_we_s     = 1'b0;
        line_wdata_s = wdata;
        case (state_q)
            IDLE: begin
                if (req_s && !hit_s) begin
                    cnt_d  = 4'd0;
                    vtag_d = tag_q[idx_s];
                    if (valid_q[idx_s] && dirty_q[idx_s]) begin
                        state_d = WB;
                    end else begin
                        state_d = REFILL;
                    end
                end else if (req_s && we) begin
                    line_we_s      = 1'b1;
                    line_wdata_s   = wdata;
                    dirty_d[idx_s] = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WB: begin
                if (cnt_q == LAT_LAST) begin
                    mem_we_s       = 1'b1;
                    dirty_d[idx_s] = 1'b0;
                    cnt_d          = 4'd0;
                    state_d        = REFILL;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            REFILL: begin
                if (cnt_q == LAT_LAST) begin
                    line_we_s      = 1'b1;
                    fill_s         = 1'b1;
                    line_wdata_s   = mem_q[addr];
                    valid_d[idx_s] = 1'b1;
                    dirty_d[idx_s] = 1'b0;
                    cnt_d          = 4'd0;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Control state: FSM, latency counter, victim tag and line status bits; reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            vtag_q  <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vtag_q  <= vtag_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Line storage: store hits and refills write data; only refills replace the tag.
    always_ff @(posedge clk) begin
        if (!rst && line_we_s) begin
            data_q[idx_s] <= line_wdata_s;
        end
        if (!rst && fill_s) begin
            tag_q[idx_s] <= tag_s;
        end
    end

    // Backing memory: written only by a completed write-back, never cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_s) begin
            mem_q[{vtag_q, idx_s}] <= data_q[idx_s];
        end
    end

`ifdef DCACHE_STATS_EN
    logic        after_fill_q, after_fill_d;
    logic [15:0] hit_q, hit_d, miss_q, miss_d;

    // Saturating counters; the completion cycle following a refill belongs to the miss, not a hit.
    always_comb begin
        after_fill_d = (state_q == REFILL) && (cnt_q == LAT_LAST);
        hit_d        = hit_q;
        miss_d       = miss_q;
        if (state_q == IDLE && req_s && hit_s && !after_fill_q && hit_q != 16'hFFFF) begin
            hit_d = hit_q + 16'd1;
        end else begin
            hit_d = hit_q;
        end
        if (state_q == IDLE && req_s && !hit_s && miss_q != 16'hFFFF) begin
            miss_d = miss_q + 16'd1;
        end else begin
            miss_d = miss_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            after_fill_q <= 1'b0;
            hit_q        <= 16'd0;
            miss_q       <= 16'd0;
        end else begin
            after_fill_q <= after_fill_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = 16'd0;
    assign miss_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Self-checking bench for d_cache_ctrl (LINES=16, MEM_LATENCY=4) with a
// reference cache/memory model feeding an expected-result scoreboard.
module tb_d_cache_ctrl;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst, we, re;
    logic [7:0]  addr, dbg_addr;
    logic [31:0] wdata, rdata, dbg_data;
    logic        stall;
    logic [15:0] hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    d_cache_ctrl #(.LINES(16), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .stall(stall), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model
    logic [31:0] mm [256];
    logic        cv [16];
    logic        cd [16];
    logic [3:0]  ct [16];
    logic [31:0] cdat [16];
    int          m_hits, m_misses;

    int          exp_stall_q [$];
    logic [31:0] exp_rdata_q [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            cv[i] = 1'b0;
            cd[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic model_push(input logic w, input logic r, input logic [7:0] a, input logic [31:0] d);
        logic [3:0] i;
        logic [3:0] t;
        int         st;
        i = a[3:0];
        t = a[7:4];
        if (cv[i] && ct[i] == t) begin
            st = 0;
            m_hits++;
        end else begin
            if (cv[i] && cd[i]) begin
                mm[{ct[i], i}] = cdat[i];
                st = 2 * LAT + 1;
            end else begin
                st = LAT + 1;
            end
            cv[i]   = 1'b1;
            cd[i]   = 1'b0;
            ct[i]   = t;
            cdat[i] = mm[a];
            m_misses++;
        end
        if (w) begin
            cdat[i] = d;
            cd[i]   = 1'b1;
        end
        exp_stall_q.push_back(st);
        exp_rdata_q.push_back((r && !w) ? cdat[i] : 32'd0);
    endtask

    task automatic do_access(input string tag, input logic w, input logic r, input logic [7:0] a, input logic [31:0] d);
        int          n;
        int          es;
        logic [31:0] er;
        bit          done;
        model_push(w, r, a, d);
        we = w; re = r; addr = a; wdata = d;
        n = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall) begin
                n++;
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
            end
        end
        es = exp_stall_q.pop_front();
        er = exp_rdata_q.pop_front();
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_stall_cycles"}, 32'(n), 32'(es));
        check_eq({tag, "_rdata"}, rdata, er);
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0;
    endtask

    task automatic check_dbg(input string tag, input logic [7:0] a);
        logic [31:0] e;
        dbg_addr = a;
        #1;
        if (cv[a[3:0]] && cd[a[3:0]] && ct[a[3:0]] == a[7:4]) e = cdat[a[3:0]];
        else e = mm[a];
        check_eq(tag, dbg_data, e);
    endtask

    task automatic check_counters(input string tag);
`ifdef DCACHE_STATS_EN
        check_eq({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(m_hits));
        check_eq({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(m_misses));
`else
        check_eq({tag, "_hit_cnt"}, 32'(hit_cnt), 32'd0);
        check_eq({tag, "_miss_cnt"}, 32'(miss_cnt), 32'd0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; we = 1'b0; re = 1'b1; addr = 8'h05; wdata = 32'd0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; re = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0]  ra;
        logic [31:0] rd;
        logic        rw, rr;
        for (int i = 0; i < 256; i++) mm[i] = 32'd0;
        dbg_addr = 8'h00;
        model_reset();
        do_reset();
        check_counters("after_reset");

        // populate backing memory through dirty evictions
        do_access("pre_st05", 1'b1, 1'b0, 8'h05, 32'hDEADBEEF);
        do_access("pre_st15", 1'b1, 1'b0, 8'h15, 32'hCAFEF00D);
        do_access("pre_ld25", 1'b0, 1'b1, 8'h25, 32'h0);
        check_dbg("pre_dbg05", 8'h05);
        check_dbg("pre_dbg15", 8'h15);
        do_reset();

        // cold miss then hit, with counters
        do_access("ld05_miss", 1'b0, 1'b1, 8'h05, 32'h0);
        do_access("ld05_hit", 1'b0, 1'b1, 8'h05, 32'h0);
        check_counters("cold_miss");

        // store hit, load hit, debug read of dirty line
        do_access("st05_hit", 1'b1, 1'b0, 8'h05, 32'h12345678);
        do_access("ld05_after_st", 1'b0, 1'b1, 8'h05, 32'h0);
        check_dbg("dbg05_dirty", 8'h05);

        // dirty victim eviction
        do_access("ld15_dirty", 1'b0, 1'b1, 8'h15, 32'h0);
        check_dbg("dbg05_mem", 8'h05);
        check_counters("dirty_evict");

        // reset in second refill cycle
        we = 1'b0; re = 1'b1; addr = 8'h05;
        @(negedge clk);
        check_eq("midrst_miss_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_stall_in_rst", 32'(stall), 32'd0);
        check_eq("midrst_rdata_in_rst", rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; re = 1'b0;
        model_reset();
        @(negedge clk);
        check_eq("midrst_idle_stall", 32'(stall), 32'd0);
        check_counters("midrst");
        @(posedge clk); #1;
        do_access("ld05_after_rst", 1'b0, 1'b1, 8'h05, 32'h0);

        // we and re together act as a store
        do_access("st_rw22", 1'b1, 1'b1, 8'h22, 32'hA5A5A5A5);
        do_access("ld22", 1'b0, 1'b1, 8'h22, 32'h0);

        // idle cycle gives no load data
        @(negedge clk);
        check_eq("idle_rdata", rdata, 32'd0);
        check_eq("idle_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;

        // random mix over a small conflicting address set
        for (int k = 0; k < 40; k++) begin
            ra = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            rd = $urandom;
            rw = 1'($urandom_range(0, 1));
            rr = rw ? 1'($urandom_range(0, 1)) : 1'b1;
            do_access("rnd", rw, rr, ra, rd);
            check_dbg("rnd_dbg", {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))});
        end
        check_counters("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
